segment_write_arbiter: RTL and testbench

Shares the 4-digit seven-segment display between two Avalon-style writers. It sits between the requesters and `segment_avalon` and owns that block's `write`/`write_data` inputs. Grants are round-robin, and each accepted value is held on the display for a minimum dwell time. Values above the displayable range are saturated to 9999 before being forwarded.

---
 rtl/segment_write_arbiter.sv | 125 ++++++++++++
 tb/tb_segment_write_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_write_arbiter.sv
// segment_write_arbiter
// Shares the seven-segment display between two Avalon-style writers.
// Grants are round-robin. Each accepted value is held for at least
// HOLD_CYCLES cycles. Values above 9999 are clamped to 9999.
//
// Ports:
//   clk, reset                    clock; asynchronous active-high reset
//   a_write, a_write_data         requester A write request and value
//   a_waitrequest                 high while A's write is not accepted (combinational)
//   b_write, b_write_data         requester B write request and value
//   b_waitrequest                 high while B's write is not accepted (combinational)
//   seg_write                     one-cycle write strobe to segment_avalon
//   seg_write_data                displayed value, always <= 9999
//   seg_sat                       pulses with seg_write when the value was clamped
//   owner                         source of the current value (0 = A, 1 = B)
//   busy                          high while the dwell is in progress
module segment_write_arbiter #(
    parameter int unsigned HOLD_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_write,
    input  logic [15:0] a_write_data,
    output logic        a_waitrequest,
    input  logic        b_write,
    input  logic [15:0] b_write_data,
    output logic        b_waitrequest,
    output logic        seg_write,
    output logic [15:0] seg_write_data,
    output logic        seg_sat,
    output logic        owner,
    output logic        busy
);

    localparam int unsigned CNT_W   = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned DATA_W  = 16;
    localparam logic [DATA_W-1:0] MAX_VAL = DATA_W'(9999);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               last, last_d;
    logic               grant_a, grant_b, accept;
    logic [DATA_W-1:0]  sel_data, sat_data, seg_data_d;
    logic               over, owner_d, seg_write_d, seg_sat_d;

    // Round-robin grant: a tie goes to the requester that was not served last.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset && state == IDLE) begin
            grant_a = a_write && (!b_write || last);
            grant_b = b_write && (!a_write || !last);
        end
    end

    assign accept        = grant_a || grant_b;
    assign a_waitrequest = !grant_a;
    assign b_waitrequest = !grant_b;

    // Saturate the granted value to the displayable range.
    assign sel_data = grant_b ? b_write_data : a_write_data;
    assign over     = sel_data > MAX_VAL;
    assign sat_data = over ? MAX_VAL : sel_data;

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt;
        last_d      = last;
        owner_d     = owner;
        seg_data_d  = seg_write_data;
        seg_write_d = 1'b0;
        seg_sat_d   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_d     = HOLD;
                    cnt_d       = CNT_W'(HOLD_CYCLES - 1);
                    last_d      = grant_b;
                    owner_d     = grant_b;
                    seg_data_d  = sat_data;
                    seg_write_d = 1'b1;
                    seg_sat_d   = over;
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; last resets to B so A wins the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            last           <= 1'b1;
            owner          <= 1'b0;
            seg_write_data <= '0;
            seg_write      <= 1'b0;
            seg_sat        <= 1'b0;
        end else begin
            state          <= state_d;
            cnt            <= cnt_d;
            last           <= last_d;
            owner          <= owner_d;
            seg_write_data <= seg_data_d;
            seg_write      <= seg_write_d;
            seg_sat        <= seg_sat_d;
        end
    end

    assign busy = (state == HOLD);

endmodule

// File: tb/tb_segment_write_arbiter.sv
// Directed bench for segment_write_arbiter (HOLD_CYCLES = 8, 20 ns clock).
// Expected strobes are queued when a grant is driven and checked when
// seg_write appears.
module tb_segment_write_arbiter;

    localparam int unsigned HOLD = 8;

    logic        clk;
    logic        reset;
    logic        a_write;
    logic [15:0] a_write_data;
    logic        a_waitrequest;
    logic        b_write;
    logic [15:0] b_write_data;
    logic        b_waitrequest;
    logic        seg_write;
    logic [15:0] seg_write_data;
    logic        seg_sat;
    logic        owner;
    logic        busy;

    typedef struct packed {
        logic [15:0] data;
        logic        sat;
        logic        owner;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   strobe_cyc = 0;
    int   prev_strobe = 0;

    segment_write_arbiter #(.HOLD_CYCLES(HOLD)) dut (
        .clk            (clk),
        .reset          (reset),
        .a_write        (a_write),
        .a_write_data   (a_write_data),
        .a_waitrequest  (a_waitrequest),
        .b_write        (b_write),
        .b_write_data   (b_write_data),
        .b_waitrequest  (b_waitrequest),
        .seg_write      (seg_write),
        .seg_write_data (seg_write_data),
        .seg_sat        (seg_sat),
        .owner          (owner),
        .busy           (busy)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    function automatic exp_t model(input logic [15:0] d, input logic src);
        exp_t e;
        e.sat   = (d > 16'd9999);
        e.data  = e.sat ? 16'd9999 : d;
        e.owner = src;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one cycle, sample 1 ns after the edge and score any strobe.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (seg_write === 1'b1) begin
            prev_strobe = strobe_cyc;
            strobe_cyc  = cyc;
            if (sb.size() == 0) begin
                chk("unexpected_strobe", 32'(seg_write), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("seg_data", 32'(seg_write_data), 32'(e.data));
                chk("seg_sat", 32'(seg_sat), 32'(e.sat));
                chk("owner", 32'(owner), 32'(e.owner));
            end
        end else begin
            chk("sat_without_strobe", 32'(seg_sat), 32'd0);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy === 1'b1; i++) tick();
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Lone write from one requester: wait for its grant, then drop write.
    task automatic write_one(input logic src, input logic [15:0] d);
        if (src) begin b_write = 1'b1; b_write_data = d; end
        else     begin a_write = 1'b1; a_write_data = d; end
        #1;
        for (int i = 0; i < 40 && (src ? b_waitrequest : a_waitrequest) !== 1'b0; i++) tick();
        chk("grant_timeout", 32'(src ? b_waitrequest : a_waitrequest), 32'd0);
        sb.push_back(model(d, src));
        tick();
        if (src) b_write = 1'b0;
        else     a_write = 1'b0;
    endtask

    initial begin
        reset = 1'b0; a_write = 1'b0; b_write = 1'b0;
        a_write_data = '0; b_write_data = '0;
        #5;
        // 1: reset state, waitrequest forced high even with a request present
        reset = 1'b1; a_write = 1'b1;
        #1;
        chk("rst_a_wait", 32'(a_waitrequest), 32'd1);
        chk("rst_b_wait", 32'(b_waitrequest), 32'd1);
        chk("rst_seg_write", 32'(seg_write), 32'd0);
        chk("rst_seg_data", 32'(seg_write_data), 32'd0);
        chk("rst_seg_sat", 32'(seg_sat), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        a_write = 1'b0;
        reset = 1'b0;
        #1;

        // 3: simultaneous requests alternate A, B, A
        a_write = 1'b1; a_write_data = 16'd100;
        b_write = 1'b1; b_write_data = 16'd200;
        #1;
        chk("tie1_a_wait", 32'(a_waitrequest), 32'd0);
        chk("tie1_b_wait", 32'(b_waitrequest), 32'd1);
        sb.push_back(model(16'd100, 1'b0));
        tick();
        a_write = 1'b0;
        for (int i = 0; i < int'(HOLD); i++) begin
            #1;
            chk("tie_hold_b_wait", 32'(b_waitrequest), 32'd1);
            tick();
        end
        chk("tie2_b_wait", 32'(b_waitrequest), 32'd0);
        sb.push_back(model(16'd200, 1'b1));
        tick();
        chk("tie_spacing", 32'(strobe_cyc - prev_strobe), 32'(HOLD + 1));
        a_write = 1'b1;
        #1;
        for (int i = 0; i < 40 && a_waitrequest !== 1'b0; i++) tick();
        chk("tie3_a_wait", 32'(a_waitrequest), 32'd0);
        chk("tie3_b_wait", 32'(b_waitrequest), 32'd1);
        sb.push_back(model(16'd100, 1'b0));
        tick();
        a_write = 1'b0; b_write = 1'b0;

        // 2: lone A write, busy for exactly HOLD cycles
        wait_idle();
        a_write = 1'b1; a_write_data = 16'd1234;
        #1;
        chk("a1234_a_wait", 32'(a_waitrequest), 32'd0);
        chk("a1234_b_wait", 32'(b_waitrequest), 32'd1);
        sb.push_back(model(16'd1234, 1'b0));
        tick();
        a_write = 1'b0;
        for (int i = 0; i < int'(HOLD); i++) begin
            chk("a1234_busy", 32'(busy), 32'd1);
            chk("a1234_strobe", 32'(seg_write), (i == 0) ? 32'd1 : 32'd0);
            tick();
        end
        chk("a1234_idle", 32'(busy), 32'd0);

        // 4: saturation, lone requester granted back-to-back
        write_one(1'b0, 16'd12345);
        wait_idle();
        write_one(1'b0, 16'd65535);
        wait_idle();
        write_one(1'b0, 16'd9999);
        wait_idle();

        // 5: B raised two cycles into A's dwell is served in the first idle cycle
        a_write = 1'b1; a_write_data = 16'd500;
        #1;
        chk("late_a_wait", 32'(a_waitrequest), 32'd0);
        sb.push_back(model(16'd500, 1'b0));
        tick();
        a_write = 1'b0;
        tick();
        b_write = 1'b1; b_write_data = 16'd3999;
        #1;
        for (int i = 0; i < 20 && busy === 1'b1; i++) begin
            chk("late_b_wait_hold", 32'(b_waitrequest), 32'd1);
            tick();
        end
        chk("late_b_wait_idle", 32'(b_waitrequest), 32'd0);
        sb.push_back(model(16'd3999, 1'b1));
        tick();
        chk("late_spacing", 32'(strobe_cyc - prev_strobe), 32'(HOLD + 1));
        b_write = 1'b0;
        wait_idle();

        // 6: reset in the middle of a dwell clears outputs at once
        b_write = 1'b1; b_write_data = 16'd4321;
        #1;
        chk("rst6_b_wait", 32'(b_waitrequest), 32'd0);
        sb.push_back(model(16'd4321, 1'b1));
        tick();
        b_write = 1'b0;
        tick(); tick(); tick();
        reset = 1'b1;
        a_write = 1'b1; a_write_data = 16'd7;
        b_write = 1'b1; b_write_data = 16'd8;
        #1;
        chk("mid_rst_data", 32'(seg_write_data), 32'd0);
        chk("mid_rst_owner", 32'(owner), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_a_wait", 32'(a_waitrequest), 32'd1);
        chk("mid_rst_b_wait", 32'(b_waitrequest), 32'd1);
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("post_rst_a_wait", 32'(a_waitrequest), 32'd0);
        chk("post_rst_b_wait", 32'(b_waitrequest), 32'd1);
        sb.push_back(model(16'd7, 1'b0));
        tick();
        a_write = 1'b0;
        for (int i = 0; i < 40 && b_waitrequest !== 1'b0; i++) tick();
        chk("post_rst_b_grant", 32'(b_waitrequest), 32'd0);
        sb.push_back(model(16'd8, 1'b1));
        tick();
        b_write = 1'b0;
        wait_idle();
        tick();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
